// File: rtl/axis_hdr_pkg.sv
// Shared types and byte-count/keep helpers for the header extract datapath.
package axis_hdr_pkg;

    // Widest bus the helpers handle, in bytes; callers size-cast results down.
    localparam int MAX_BYTES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BODY  = 2'd1,
        FLUSH = 2'd2
    } hdr_ext_state_t;

    // Number of enabled bytes in an MSB-contiguous keep vector.
    function automatic int keep_to_cnt(input logic [MAX_BYTES-1:0] keep);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            cnt += int'(keep[i]);
        end
        return cnt;
    endfunction

    // cnt ones packed against the MSB of a w-bit keep field.
    function automatic logic [MAX_BYTES-1:0] cnt_to_keep_msb(input int cnt, input int w);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < w && i >= w - cnt) begin
                k[i] = 1'b1;
            end
        end
        return k;
    endfunction

    // cnt ones packed against the LSB.
    function automatic logic [MAX_BYTES-1:0] cnt_to_keep_lsb(input int cnt);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < cnt) begin
                k[i] = 1'b1;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Combinational merge of the carried-over residual bytes with the leading
// bytes of the incoming beat. Both data words are MSB-aligned with zeros in
// unused byte lanes, so the merge is an OR of the residual with the shifted input.
module axis_byte_merge #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic [DATA_WD-1:0] res_data,
    input  logic [CNT_WD-1:0]  res_cnt,
    input  logic [DATA_WD-1:0] in_data,
    input  logic [CNT_WD-1:0]  in_cnt,
    output logic [DATA_WD-1:0] merged_data,
    output logic [CNT_WD-1:0]  merged_cnt,
    output logic [DATA_WD-1:0] new_res_data,
    output logic [CNT_WD-1:0]  new_res_cnt
);

    localparam logic [CNT_WD:0] W_BYTES = (CNT_WD + 1)'(DATA_BYTE_WD);

    logic [CNT_WD:0] sum;

    // Append input bytes after the residual; whatever overflows one beat becomes the next residual.
    always_comb begin
        sum         = {1'b0, res_cnt} + {1'b0, in_cnt};
        merged_data = res_data | (in_data >> (8 * int'(res_cnt)));
        if (res_cnt == '0) begin
            new_res_data = '0;
        end else begin
            new_res_data = in_data << (8 * (DATA_BYTE_WD - int'(res_cnt)));
        end
        if (sum > W_BYTES) begin
            merged_cnt  = CNT_WD'(DATA_BYTE_WD);
            new_res_cnt = CNT_WD'(sum - W_BYTES);
        end else begin
            merged_cnt  = sum[CNT_WD-1:0];
            new_res_cnt = '0;
        end
    end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips the first byte_extract_cnt bytes of each AXI-Stream packet onto a
// separate header port and re-packs the remaining payload into full,
// MSB-aligned beats.
//
// Handshake rule for all three ports: a transfer happens on a rising clk edge
// where valid and ready are both high; a source holds valid and its payload
// stable until that edge, and ready may change freely.
module axi_stream_extract_header
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    output logic                    valid_header,
    input  logic                    ready_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic [BYTE_CNT_WD:0]    byte_extract_cnt,
    output logic [1:0]              dbg_state
);

    localparam int CNT_WD = BYTE_CNT_WD + 1;

    hdr_ext_state_t state;

    // Residual bytes carried between beats, MSB-aligned, and their count.
    logic [DATA_WD-1:0]      res_data;
    logic [CNT_WD-1:0]       res_cnt;

    logic                    in_fire;
    logic                    out_free;
    logic [DATA_WD-1:0]      din_m;
    logic [CNT_WD-1:0]       k_cnt;
    logic [CNT_WD-1:0]       hdr_cnt;
    logic [CNT_WD-1:0]       first_res_cnt;
    logic [DATA_WD-1:0]      first_res_data;
    logic [DATA_WD-1:0]      hdr_data;
    logic [DATA_BYTE_WD-1:0] hdr_keep;
    logic [DATA_WD-1:0]      m_data;
    logic [CNT_WD-1:0]       m_cnt;
    logic [DATA_BYTE_WD-1:0] m_keep;
    logic [DATA_WD-1:0]      nr_data;
    logic [CNT_WD-1:0]       nr_cnt;

    assign dbg_state = state;
    assign out_free  = !valid_out || ready_out;
    // A new packet's first beat waits until the previous header has left.
    assign ready_in  = rst_n && (state != FLUSH) && out_free &&
                       ((state != IDLE) || !valid_header || ready_header);
    assign in_fire   = valid_in && ready_in;

    // Zero disabled byte lanes so residual and merge logic can OR words together.
    always_comb begin
        din_m = '0;
        for (int b = 0; b < DATA_BYTE_WD; b++) begin
            if (keep_in[DATA_BYTE_WD-1-b]) begin
                din_m[DATA_WD-1-8*b -: 8] = data_in[DATA_WD-1-8*b -: 8];
            end
        end
    end

    // First-beat split: header takes min(K, N) bytes, residual keeps what is left.
    always_comb begin
        k_cnt          = CNT_WD'(keep_to_cnt(MAX_BYTES'(keep_in)));
        hdr_cnt        = (k_cnt < byte_extract_cnt) ? k_cnt : byte_extract_cnt;
        first_res_cnt  = (k_cnt > byte_extract_cnt) ? (k_cnt - byte_extract_cnt) : '0;
        first_res_data = din_m << (8 * int'(byte_extract_cnt));
        hdr_data       = din_m >> (8 * (DATA_BYTE_WD - int'(hdr_cnt)));
        hdr_keep       = DATA_BYTE_WD'(cnt_to_keep_lsb(int'(hdr_cnt)));
        m_keep         = DATA_BYTE_WD'(cnt_to_keep_msb(int'(m_cnt), DATA_BYTE_WD));
    end

    axis_byte_merge #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .CNT_WD       (CNT_WD)
    ) u_merge (
        .res_data     (res_data),
        .res_cnt      (res_cnt),
        .in_data      (din_m),
        .in_cnt       (k_cnt),
        .merged_data  (m_data),
        .merged_cnt   (m_cnt),
        .new_res_data (nr_data),
        .new_res_cnt  (nr_cnt)
    );

    // Packet FSM with registered header and payload outputs; a load in the same cycle as a drain wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            res_data     <= '0;
            res_cnt      <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
        end else begin
            if (valid_out && ready_out) begin
                valid_out <= 1'b0;
            end
            if (valid_header && ready_header) begin
                valid_header <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        valid_header <= 1'b1;
                        data_header  <= hdr_data;
                        keep_header  <= hdr_keep;
                        res_data     <= first_res_data;
                        res_cnt      <= first_res_cnt;
                        if (!last_in) begin
                            state <= BODY;
                        end else if (first_res_cnt != '0) begin
                            state <= FLUSH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                BODY: begin
                    if (in_fire) begin
                        valid_out <= 1'b1;
                        data_out  <= m_data;
                        keep_out  <= m_keep;
                        last_out  <= last_in && (nr_cnt == '0);
                        res_data  <= nr_data;
                        res_cnt   <= nr_cnt;
                        if (last_in) begin
                            state <= (nr_cnt != '0) ? FLUSH : IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        valid_out <= 1'b1;
                        data_out  <= res_data;
                        keep_out  <= DATA_BYTE_WD'(cnt_to_keep_msb(int'(res_cnt), DATA_BYTE_WD));
                        last_out  <= 1'b1;
                        res_data  <= '0;
                        res_cnt   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
